// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: FSM state encoding, default
// sizing constants and a small state-decode helper.
package tick_gen_pkg;

  // Default counter/divisor width and reset divisor (1 Hz from 100 MHz).
  localparam int TG_CNT_W       = 28;
  localparam int TG_DEFAULT_DIV = 100000000;
  localparam int TG_TCNT_W      = 8;

  // Two-bit FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // RUN and HOLD are the "busy" states; the counter only lives there.
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/tick_gen_counter.sv
// Period counter: counts 0..P-1 and wraps, with synchronous clear and hold.
// The terminal-count flag compares against P-1 of the caller-supplied
// effective period (always >= 1).
module tick_counter
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = TG_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last  = i_period - CNT_W'(1);
  // ">=" rather than "==" so a stale count can never run past the period.
  assign o_tc    = (r_count >= w_last);
  assign o_count = r_count;

  // Counter register: clear wins, otherwise advance-and-wrap or hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_adv) begin
      if (o_tc) r_count <= '0;
      else      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick generator: single-cycle tick once every P clocks, a
// ~50% square wave at the same rate, pause/resume, and a one-shot mode.
// All outputs are registered.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = TG_CNT_W,
  parameter int DEFAULT_DIV = TG_DEFAULT_DIV,
  parameter int TCNT_W      = TG_TCNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              oneshot,
  input  logic              load,
  input  logic [CNT_W-1:0]  div_in,
  output logic              tick,
  output logic              square,
  output logic              busy,
  output logic              done,
  output logic [TCNT_W-1:0] tick_cnt
);

  state_e              r_state;
  logic [CNT_W-1:0]    r_div;
  logic                r_oneshot;
  logic                r_tick;
  logic                r_square;
  logic                r_busy;
  logic                r_done;
  logic [TCNT_W-1:0]   r_tick_cnt;

  logic [CNT_W-1:0]    w_period;
  logic [CNT_W-1:0]    w_half;
  logic [CNT_W-1:0]    w_count;
  logic                w_tc;
  logic                w_clr;
  logic                w_adv;

  // Divisors 0 and 1 both mean "every cycle".
  assign w_period = (r_div == '0) ? CNT_W'(1) : r_div;
  assign w_half   = w_period >> 1;

  // Counter restarts on load or on leaving IDLE; it advances on every
  // enabled RUN/HOLD cycle, so the HOLD->RUN edge itself counts as a step
  // and a pause delays the tick by exactly its own length.
  assign w_clr = load || ((r_state == ST_IDLE) && enable);
  assign w_adv = !load && enable && is_active(r_state);

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_adv    (w_adv),
    .i_period (w_period),
    .o_count  (w_count),
    .o_tc     (w_tc)
  );

  // Control FSM with registered outputs; load overrides every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div      <= CNT_W'(DEFAULT_DIV);
      r_oneshot  <= 1'b0;
      r_tick     <= 1'b0;
      r_square   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_tick <= 1'b0;
      if (load) begin
        // A load on the terminal count swallows that tick (r_tick stays 0).
        r_div    <= div_in;
        r_square <= 1'b0;
        r_done   <= 1'b0;
        if (enable) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          // Reloading a running timer keeps its mode and tick history.
          if (!is_active(r_state)) begin
            r_oneshot  <= oneshot;
            r_tick_cnt <= '0;
          end
        end else begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_tick_cnt <= '0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable) begin
              r_state    <= ST_RUN;
              r_oneshot  <= oneshot;
              r_tick_cnt <= '0;
              r_busy     <= 1'b1;
              r_square   <= 1'b0;
            end
          end
          ST_RUN, ST_HOLD: begin
            if (!enable) begin
              // Freeze: counter holds, square and tick_cnt keep their values.
              r_state <= ST_HOLD;
            end else begin
              r_state  <= ST_RUN;
              r_square <= (w_count < w_half);
              if (w_tc) begin
                r_tick     <= 1'b1;
                r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
                if (r_oneshot) begin
                  r_state  <= ST_DONE;
                  r_busy   <= 1'b0;
                  r_square <= 1'b0;
                end
              end
            end
          end
          ST_DONE: begin
            // done rises the cycle after the final tick and holds until
            // enable drops.
            if (!enable) begin
              r_state    <= ST_IDLE;
              r_done     <= 1'b0;
              r_tick_cnt <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick     = r_tick;
  assign square   = r_square;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with an 10-cycle reset divisor.
module tb_tick_gen;

  localparam int CNT_W  = 28;
  localparam int TCNT_W = 8;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              oneshot;
  logic              load;
  logic [CNT_W-1:0]  div_in;
  logic              tick;
  logic              square;
  logic              busy;
  logic              done;
  logic [TCNT_W-1:0] tick_cnt;

  int total;
  int bad;

  tick_gen #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (10),
    .TCNT_W      (TCNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .oneshot  (oneshot),
    .load     (load),
    .div_in   (div_in),
    .tick     (tick),
    .square   (square),
    .busy     (busy),
    .done     (done),
    .tick_cnt (tick_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; "cycle c" begins here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"},   32'(tick),     32'd0);
    chk({tag, "_square"}, 32'(square),   32'd0);
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_done"},   32'(done),     32'd0);
    chk({tag, "_tcnt"},   32'(tick_cnt), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; enable = 1'b0; oneshot = 1'b0; load = 1'b0; div_in = '0;

    // Reset state
    #1 reset = 1'b1;
    #2 chk_all_zero("rst");
    step(); step();
    #3 reset = 1'b0;

    // Idle after release: nothing happens without enable/load
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_tick", 32'(tick), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Periodic P=10 from edge 0: ticks at 10, 20, 30
    enable = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      step();
      chk("p10_tick", 32'(tick), 32'((c == 10) || (c == 20) || (c == 30)));
      chk("p10_tcnt", 32'(tick_cnt), 32'(c / 10));
      chk("p10_busy", 32'(busy), 32'd1);
    end

    // Load with enable low: back to IDLE
    load = 1'b1; enable = 1'b0; div_in = 28'd4;
    step();
    chk("ld_idle_busy", 32'(busy), 32'd0);
    chk("ld_idle_tcnt", 32'(tick_cnt), 32'd0);
    chk("ld_idle_tick", 32'(tick), 32'd0);

    // One-shot P=4: tick in cycle 4, done from cycle 5
    load = 1'b1; enable = 1'b1; oneshot = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      step();
      load = 1'b0;
      chk("os_tick", 32'(tick), 32'(c == 4));
      chk("os_done", 32'(done), 32'(c >= 5));
      chk("os_busy", 32'(busy), 32'(c < 4));
      chk("os_tcnt", 32'(tick_cnt), 32'(c >= 4));
    end
    enable = 1'b0; oneshot = 1'b0;
    step();
    chk("os_off_done", 32'(done), 32'd0);
    chk("os_off_tcnt", 32'(tick_cnt), 32'd0);
    chk("os_off_busy", 32'(busy), 32'd0);

    // Pause P=10: enable low in cycles 3..9, tick lands in cycle 17
    load = 1'b1; div_in = 28'd10; enable = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      step();
      load = 1'b0;
      enable = !((c >= 3) && (c <= 9));
      chk("hold_tick", 32'(tick), 32'(c == 17));
      chk("hold_sq", 32'(square), 32'(((c >= 1) && (c <= 12)) || (c >= 18)));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_tcnt", 32'(tick_cnt), 32'(c >= 17));
    end

    // P=8, reload div 3 while counter=6: tick 3 cycles after the load
    load = 1'b1; div_in = 28'd8;
    for (int c = 0; c <= 13; c++) begin
      step();
      load = (c == 6);
      if (c == 0) div_in = 28'd3;
      chk("rl_tick", 32'(tick), 32'((c == 10) || (c == 13)));
      chk("rl_tcnt", 32'(tick_cnt), (c < 10) ? 32'd1 : ((c < 13) ? 32'd2 : 32'd3));
    end

    // P=8, load exactly at counter=7 swallows the tick
    load = 1'b1; div_in = 28'd8;
    for (int c = 0; c <= 16; c++) begin
      step();
      load = (c == 7);
      chk("tcld_tick", 32'(tick), 32'(c == 16));
      chk("tcld_tcnt", 32'(tick_cnt), (c == 16) ? 32'd4 : 32'd3);
    end

    // div 0: tick every cycle, square stays low
    load = 1'b1; div_in = 28'd0;
    for (int c = 0; c <= 5; c++) begin
      step();
      load = 1'b0;
      chk("d0_tick", 32'(tick), 32'(c >= 1));
      chk("d0_sq", 32'(square), 32'd0);
      chk("d0_tcnt", 32'(tick_cnt), 32'(4 + c));
    end

    // div 1: same behaviour, load cycle suppresses its tick
    load = 1'b1; div_in = 28'd1;
    for (int c = 0; c <= 4; c++) begin
      step();
      load = 1'b0;
      chk("d1_tick", 32'(tick), 32'(c >= 1));
      chk("d1_tcnt", 32'(tick_cnt), 32'(9 + c));
    end

    // div 6: square 3 high / 3 low
    load = 1'b1; div_in = 28'd6;
    for (int c = 0; c <= 13; c++) begin
      step();
      load = 1'b0;
      chk("d6_sq", 32'(square), 32'((c >= 1) && (((c - 1) % 6) < 3)));
      chk("d6_tick", 32'(tick), 32'((c == 6) || (c == 12)));
    end

    // Asynchronous reset mid-RUN, then a full default period
    #3 reset = 1'b1;
    #1 chk_all_zero("arst");
    #2 reset = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      step();
      chk("post_tick", 32'(tick), 32'(c == 10));
      chk("post_busy", 32'(busy), 32'd1);
    end
    chk("post_tcnt", 32'(tick_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 28, the divisor and counter width in bits.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 100000000, the divisor loaded at reset (1 Hz from 100 MHz).
REQ-003 The block SHALL have parameter TCNT_W, default 8, the tick_cnt width in bits.
REQ-004 The block SHALL have port clock, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, width 1: run request; low pauses or idles the block.
REQ-007 The block SHALL have port oneshot, input, width 1: mode select, 1 for one-shot and 0 for periodic; sampled only on IDLE->RUN.
REQ-008 The block SHALL have port load, input, width 1: one-cycle strobe that latches div_in and restarts the count.
REQ-009 The block SHALL have port div_in, input, width CNT_W: new period P in clock cycles.
REQ-010 The block SHALL have port tick, output, width 1: single-cycle pulse once per period.
REQ-011 The block SHALL have port square, output, width 1: approximately 50% duty wave at the tick rate.
REQ-012 The block SHALL have port busy, output, width 1: high in RUN and HOLD.
REQ-013 The block SHALL have port done, output, width 1: high in DONE (one-shot finished).
REQ-014 The block SHALL have port tick_cnt, output, width TCNT_W: count of ticks since the last IDLE; wraps modulo 2^TCNT_W.

Function
REQ-015 Effective period SHALL be P = max(div_reg, 1); div 0 and div 1 both SHALL give a tick every cycle.
REQ-016 The internal counter SHALL count up 0..P-1 in RUN and wrap to 0; the terminal count is the cycle with counter == P-1.
REQ-017 tick SHALL be registered: when entering RUN at edge k, pulses SHALL occur in cycles k+P, k+2P, and so on, each exactly one cycle wide.
REQ-018 square SHALL be registered, high while the counter is < floor(P/2) (from the cycle after entering RUN) and low otherwise; for P=1 it SHALL remain low.
REQ-019 The FSM SHALL have states IDLE, RUN, HOLD and DONE.
REQ-020 IDLE->RUN SHALL occur on enable=1: oneshot is latched, the counter is 0 and tick_cnt is cleared.
REQ-021 RUN->HOLD SHALL occur on enable=0: the counter, square and tick_cnt freeze, and no tick is issued.
REQ-022 HOLD->RUN SHALL occur on enable=1: counting resumes from the frozen value, so the pause adds exactly its length to the period.
REQ-023 RUN->DONE SHALL occur at the terminal count when latched oneshot=1: that tick is issued, then done=1 and no further ticks.
REQ-024 DONE->IDLE SHALL occur on enable=0; DONE SHALL persist while enable=1.
REQ-025 load SHALL take effect from any state and SHALL take priority over all other events: div_reg <= div_in, counter <= 0, and the next state is RUN if enable=1, else IDLE.
REQ-026 In RUN, load SHALL keep tick_cnt and the latched mode; from DONE or IDLE it SHALL behave as IDLE->RUN.
REQ-027 load coinciding with the terminal count SHALL suppress that tick and SHALL NOT increment tick_cnt.
REQ-028 enable falling on the terminal-count cycle SHALL enter HOLD with the counter at P-1, and the tick SHALL fire one cycle after resume.
REQ-029 tick_cnt SHALL increment in the same cycle tick is asserted.

Reset
REQ-030 reset=1 SHALL force, asynchronously: state IDLE, counter 0, div_reg DEFAULT_DIV, and tick, square, busy, done and tick_cnt all 0, without waiting for a clock edge.
REQ-031 Release of reset SHALL NOT produce a tick or any state change until enable or load is sampled.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit) and the default CNT_W/DEFAULT_DIV constants.
REQ-033 The block SHALL contain one sub-module, tick_counter: a CNT_W up-counter with clear, hold and terminal-count compare against P-1, instantiated once.

Verification
REQ-034 Bench (DEFAULT_DIV=10): after reset, enable=1 from edge 0 -> tick in cycles 10, 20 and 30; tick_cnt 1, 2, 3; busy=1.
REQ-035 load div_in=4, oneshot=1, enable=1 -> a single tick in cycle 4; done=1 from cycle 5 on; enable=0 -> IDLE, done=0 and tick_cnt=0.
REQ-036 P=10, enable low in cycles 3..9 (7 cycles) -> the first tick SHALL land in cycle 17; square frozen during the pause.
REQ-037 P=8, load div_in=3 at counter=6 -> the next tick 3 cycles after load; a load exactly at counter=7 -> no tick that cycle and tick_cnt unchanged.
REQ-038 div_in=0 and div_in=1 -> tick every cycle; div_in=6 -> square high 3 cycles and low 3 cycles, repeating.
REQ-039 reset asserted between edges mid-RUN -> all outputs 0 before the next clock edge; after release, a full P=10 period SHALL elapse before the first tick.
